event_priority_encoder: RTL

- Parametrised, registered successor to the combinational 8-to-3 one-hot encoder.
- Captures rising edges on N request lines into a sticky pending vector.
- Presents the pending lines one at a time as a binary index, in a selectable priority order, over a valid/ready handshake.
- Sits between raw event/interrupt sources and a single consumer, such as a controller FSM or a display driver.

---
 rtl/event_priority_encoder_if.sv | 42 ++++
 rtl/event_priority_encoder.sv | 88 ++++++++
 2 files changed

// File: rtl/event_priority_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : event_priority_encoder_if
//  Description : Request lines, valid/ready grant handshake and status for the
//                event priority encoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface event_priority_encoder_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     in;
    logic [IDX_W-1:0] out;
    logic             valid;
    logic             ready;
    logic             multi;
    logic             overflow;
    logic [N-1:0]     pending;

    // Encoder side: sees requests and ready, drives the grant and status.
    modport master (
        input  in,
        input  ready,
        output out,
        output valid,
        output multi,
        output overflow,
        output pending
    );

    // Source/consumer side.
    modport slave (
        output in,
        output ready,
        input  out,
        input  valid,
        input  multi,
        input  overflow,
        input  pending
    );
endinterface
`default_nettype wire

// File: rtl/event_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : event_priority_encoder
//  Description : Captures rising edges on N request lines into a sticky
//                pending vector and presents them one at a time as a binary
//                index over a valid/ready handshake, lowest- or highest-index
//                first.
//  Revision    : 1.0  initial release
// ============================================================================
module event_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int MODE  = 0
) (
    input wire logic                  clk,
    input wire logic                  rst_n,
    event_priority_encoder_if.master  bus
);

    logic [N-1:0]     r_in_prev;
    logic [N-1:0]     r_pending;
    logic [IDX_W-1:0] r_out;
    logic             r_valid;
    logic             r_overflow;

    logic [N-1:0]     w_rise;
    logic             w_acc;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_pending_nx;
    logic [IDX_W-1:0] w_enc;

    // Edge detect, accept decode and next pending vector.
    always_comb begin
        w_rise       = bus.in & ~r_in_prev;
        w_acc        = r_valid & bus.ready;
        w_clr        = w_acc ? (N'(1) << r_out) : '0;
        // A rise on the bit being cleared keeps it set: it is a new event.
        w_pending_nx = (r_pending & ~w_clr) | w_rise;
    end

    // Priority encode of the next pending vector; empty vector encodes to 0.
    generate
        if (MODE == 0) begin : g_lowest_first
            always_comb begin
                w_enc = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (w_pending_nx[i]) w_enc = IDX_W'(i);
                end
            end
        end else begin : g_highest_first
            always_comb begin
                w_enc = '0;
                for (int i = 0; i < N; i++) begin
                    if (w_pending_nx[i]) w_enc = IDX_W'(i);
                end
            end
        end
    endgenerate

    // State update; the output register only reloads when empty or accepted,
    // so a presented index stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_prev  <= '0;
            r_pending  <= '0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_in_prev  <= bus.in;
            r_pending  <= w_pending_nx;
            r_overflow <= |(w_rise & r_pending & ~w_clr);
            if (!r_valid || w_acc) begin
                r_out   <= w_enc;
                r_valid <= |w_pending_nx;
            end
        end
    end

    assign bus.out      = r_out;
    assign bus.valid    = r_valid;
    assign bus.overflow = r_overflow;
    assign bus.pending  = r_pending;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign bus.multi    = |(r_pending & (r_pending - N'(1)));

endmodule
`default_nettype wire
